// File: rtl/serial_comparator_32.sv
// Byte-serial signed 32-bit magnitude comparator.
// Ports: clock, reset (async, active-low), ctrl_compare start strobe,
//   a/b operands, LT/EQ registered result, data_resultRDY one-cycle
//   result-valid pulse, busy while a comparison is running.
//   Optional macro SERIAL_CMP_UNSIGNED_EN adds is_unsigned, which
//   selects a plain unsigned compare for that operation.
module serial_comparator_32 (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_compare,
`ifdef SERIAL_CMP_UNSIGNED_EN
   input  logic        is_unsigned,
`endif
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        LT,
   output logic        EQ,
   output logic        data_resultRDY,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        lt_acc_q, lt_acc_d;
   logic        eq_acc_q, eq_acc_d;
   logic        lt_q, lt_d;
   logic        eq_q, eq_d;
`ifdef SERIAL_CMP_UNSIGNED_EN
   logic        uns_q, uns_d;
`endif

   logic [7:0]  byte_a;
   logic [7:0]  byte_b;
   logic        lt_step;
   logic        eq_step;
   logic        sign_fix;

   always_comb begin
      unique case (idx_q)
         2'd0: begin byte_a = a_q[7:0];   byte_b = b_q[7:0];   end
         2'd1: begin byte_a = a_q[15:8];  byte_b = b_q[15:8];  end
         2'd2: begin byte_a = a_q[23:16]; byte_b = b_q[23:16]; end
         default: begin
            byte_a = a_q[31:24];
            byte_b = b_q[31:24];
         end
      endcase
   end

   // A differing higher byte overrides whatever lower bytes decided.
   assign lt_step = (byte_a != byte_b) ? (byte_a < byte_b) : lt_acc_q;
   assign eq_step = eq_acc_q & (byte_a == byte_b);

   // Unsigned byte order is wrong only when the sign bits differ.
`ifdef SERIAL_CMP_UNSIGNED_EN
   assign sign_fix = (a_q[31] ^ b_q[31]) & ~uns_q;
`else
   assign sign_fix = a_q[31] ^ b_q[31];
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      lt_acc_d = lt_acc_q;
      eq_acc_d = eq_acc_q;
      lt_d     = lt_q;
      eq_d     = eq_q;
`ifdef SERIAL_CMP_UNSIGNED_EN
      uns_d    = uns_q;
`endif
      unique case (state_q)
         IDLE, DONE: begin
            state_d = (state_q == DONE) ? IDLE : state_q;
            if (ctrl_compare) begin
               state_d  = RUN;
               idx_d    = 2'd0;
               a_d      = a;
               b_d      = b;
               lt_acc_d = 1'b0;
               eq_acc_d = 1'b1;
`ifdef SERIAL_CMP_UNSIGNED_EN
               uns_d    = is_unsigned;
`endif
            end
         end
         RUN: begin
            idx_d    = idx_q + 2'd1;
            lt_acc_d = lt_step;
            eq_acc_d = eq_step;
            if (idx_q == 2'd3) begin
               state_d = DONE;
               lt_d    = sign_fix ? a_q[31] : lt_step;
               eq_d    = eq_step;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         idx_q    <= 2'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         lt_acc_q <= 1'b0;
         eq_acc_q <= 1'b1;
         lt_q     <= 1'b0;
         eq_q     <= 1'b0;
`ifdef SERIAL_CMP_UNSIGNED_EN
         uns_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         lt_acc_q <= lt_acc_d;
         eq_acc_q <= eq_acc_d;
         lt_q     <= lt_d;
         eq_q     <= eq_d;
`ifdef SERIAL_CMP_UNSIGNED_EN
         uns_q    <= uns_d;
`endif
      end
   end

   assign LT             = lt_q;
   assign EQ             = eq_q;
   assign busy           = (state_q == RUN);
   assign data_resultRDY = (state_q == DONE);

endmodule

// File: doc/serial_comparator_32.md
SERIAL_COMPARATOR_32 -- requirements
Module: serial_comparator_32

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with ports named as below.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 ctrl_compare  input  1  start strobe, sampled on rising clock edge.
REQ-005 a  input  32  operand A, two's complement; sampled only on an accepted start.
REQ-006 b  input  32  operand B, two's complement; sampled only on an accepted start.
REQ-007 LT  output  1  registered result, 1 when A < B.
REQ-008 EQ  output  1  registered result, 1 when A == B.
REQ-009 data_resultRDY  output  1  one-cycle pulse marking LT/EQ valid.
REQ-010 busy  output  1  1 while a comparison is in progress.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, DONE; busy SHALL be 1 only in RUN.
REQ-012 A start SHALL be accepted when ctrl_compare=1 at an edge in IDLE or DONE; a, b latched into internal registers; 2-bit byte index cleared to 0; eq_acc set to 1; lt_acc cleared to 0; next state RUN.
REQ-013 ctrl_compare=1 in RUN SHALL be ignored; latched operands SHALL not change.
REQ-014 Each RUN edge SHALL process one byte LSB-first (index 0 = bits 7:0, ... index 3 = bits 31:24).
REQ-015 Per-byte update: compare the byte pair as unsigned; if bytes differ, lt_acc <= (byte_A < byte_B); eq_acc <= eq_acc AND (byte_A == byte_B).
REQ-016 The byte index SHALL increment by 1 per RUN edge and wrap 3->0; the edge processing index 3 SHALL transition to DONE.
REQ-017 On the index-3 edge, LT and EQ SHALL be loaded: if a[31] != b[31], LT = latched a[31]; else LT = final lt_acc. EQ = final eq_acc.
REQ-018 Latency: start accepted at edge E0; bytes processed at E1..E4; LT/EQ updated and data_resultRDY=1 in the cycle after E4; data_resultRDY=0 in all other cycles.
REQ-019 DONE SHALL last exactly one cycle, returning to IDLE unless a new start is accepted (back-to-back compare, next result after E4 of the new start).
REQ-020 LT and EQ SHALL hold their last values until the next index-3 edge; they SHALL not change during RUN.
REQ-021 LT and EQ SHALL never both be 1.

Reset
REQ-022 reset=0 SHALL, asynchronously, force state IDLE and clear LT, EQ, data_resultRDY, busy, byte index, lt_acc, and latched operands to 0; eq_acc to 1.
REQ-023 reset asserted in RUN SHALL abort the comparison; no data_resultRDY pulse for it SHALL ever be produced.
REQ-024 After reset deassertion, the first start SHALL be accepted on the first rising edge with ctrl_compare=1.

Configuration
REQ-025 Macro SERIAL_CMP_UNSIGNED_EN, when defined, SHALL add input is_unsigned (1 bit), latched with the operands on an accepted start.
REQ-026 With the macro defined and latched is_unsigned=1, the sign correction of REQ-017 SHALL be skipped (LT = lt_acc, pure unsigned compare); with is_unsigned=0, behaviour SHALL equal the undefined case.
REQ-027 Without the macro, no is_unsigned port SHALL exist and all compares SHALL be signed.

Verification
REQ-028 a=5, b=9, start -> busy 1 for 4 cycles; data_resultRDY pulse 5th cycle; LT=1, EQ=0.
REQ-029 a=0x80000000, b=0x7FFFFFFF -> LT=1, EQ=0; swap operands -> LT=0, EQ=0.
REQ-030 a=b=0xDEADBEEF -> EQ=1, LT=0; then a=0x00000100, b=0x000000FF -> LT=0, EQ=0 (higher byte overrides lower).
REQ-031 Start a=1,b=2; reassert ctrl_compare with a=3,b=1 during RUN -> ignored, result LT=1; start in DONE cycle -> accepted, second result LT=0 after 4 more edges.
REQ-032 Reset asserted at second RUN cycle -> outputs 0 immediately, no data_resultRDY pulse; post-reset compare a=-1,b=0 -> LT=1.
REQ-033 SERIAL_CMP_UNSIGNED_EN defined, is_unsigned=1, a=0xFFFFFFFF, b=0 -> LT=0, EQ=0; is_unsigned=0 -> LT=1.
